// File: rtl/widen_fifo_pkg.sv
// Shared sizing helpers for the narrow-to-wide width-converting FIFO.
package widen_fifo_pkg;

  function automatic int unsigned wide_w(input int unsigned narrow_w, input int unsigned ratio);
    return narrow_w * ratio;
  endfunction

  function automatic int unsigned keep_w(input int unsigned narrow_w, input int unsigned ratio);
    return (narrow_w * ratio) / 8;
  endfunction

  // Stored word layout is {last, keep, data}, MSB first.
  function automatic int unsigned entry_w(input int unsigned narrow_w, input int unsigned ratio);
    return wide_w(narrow_w, ratio) + keep_w(narrow_w, ratio) + 1;
  endfunction

endpackage

// File: rtl/widen_fifo_ram.sv
// Single-clock simple-dual-port RAM with registered read; no reset so it maps to block RAM.
module widen_fifo_ram #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/widen_fifo.sv
// Packs narrow beats into wide words, buffers them in RAM and streams them out
// through a two-entry output stage (output register plus skid).
module widen_fifo
  import widen_fifo_pkg::*;
#(
  parameter int unsigned NARROW_W = 16,
  parameter int unsigned RATIO    = 4,
  parameter int unsigned DEPTH    = 512,
  parameter int unsigned ADDR_W   = $clog2(DEPTH)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NARROW_W-1:0]                   s_data,
  input  logic                                  s_valid,
  input  logic                                  s_last,
  output logic                                  s_ready,
  output logic [wide_w(NARROW_W, RATIO)-1:0]    m_data,
  output logic [keep_w(NARROW_W, RATIO)-1:0]    m_keep,
  output logic                                  m_last,
  output logic                                  m_valid,
  input  logic                                  m_ready,
  output logic [ADDR_W:0]                       count
);

  localparam int unsigned WIDE_W  = wide_w(NARROW_W, RATIO);
  localparam int unsigned KEEP_W  = keep_w(NARROW_W, RATIO);
  localparam int unsigned ENTRY_W = entry_w(NARROW_W, RATIO);
  localparam int unsigned BPL     = NARROW_W / 8;
  localparam int unsigned LANE_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int unsigned PTR_W   = ADDR_W + 1;

  logic [LANE_W-1:0]  lane;
  logic [WIDE_W-1:0]  lane_data, word_c;
  logic [KEEP_W-1:0]  lane_keep, keep_c;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr, pop_ptr, wr_ptr_nxt_c, pop_ptr_nxt_c;
  logic               accept_c, commit_c, pop_c, issue_c, full_nxt_c;
  logic [1:0]         occ_c;
  logic               rd_inflight, skid_valid;
  logic [ENTRY_W-1:0] skid_q, rdata;

  assign accept_c = s_valid && s_ready;
  assign commit_c = accept_c && ((lane == LANE_W'(RATIO - 1)) || s_last);
  assign pop_c    = m_valid && m_ready;

  // Current beat merged into the lane register at the active lane.
  always_comb begin
    word_c = lane_data;
    keep_c = lane_keep;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (lane == LANE_W'(k)) begin
        word_c[k*NARROW_W +: NARROW_W] = s_data;
        keep_c[k*BPL +: BPL]           = '1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane      <= '0;
      lane_data <= '0;
      lane_keep <= '0;
    end else if (accept_c) begin
      if (commit_c) begin
        lane      <= '0;
        lane_data <= '0;
        lane_keep <= '0;
      end else begin
        lane      <= lane + LANE_W'(1);
        lane_data <= word_c;
        lane_keep <= keep_c;
      end
    end
  end

  assign wr_ptr_nxt_c  = wr_ptr + PTR_W'(commit_c);
  assign pop_ptr_nxt_c = pop_ptr + PTR_W'(pop_c);
  assign full_nxt_c    = (wr_ptr_nxt_c[ADDR_W] != pop_ptr_nxt_c[ADDR_W]) &&
                         (wr_ptr_nxt_c[ADDR_W-1:0] == pop_ptr_nxt_c[ADDR_W-1:0]);

  // Reads are only issued if the output stage can absorb them, counting the one in flight.
  assign occ_c   = 2'(m_valid) + 2'(skid_valid) + 2'(rd_inflight) - 2'(pop_c);
  assign issue_c = (rd_ptr != wr_ptr) && (occ_c < 2'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      pop_ptr     <= '0;
      count       <= '0;
      s_ready     <= 1'b0;
      rd_inflight <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_nxt_c;
      pop_ptr     <= pop_ptr_nxt_c;
      rd_ptr      <= rd_ptr + PTR_W'(issue_c);
      count       <= wr_ptr_nxt_c - pop_ptr_nxt_c;
      s_ready     <= !full_nxt_c;
      rd_inflight <= issue_c;
    end
  end

  widen_fifo_ram #(
    .WIDTH  (ENTRY_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (commit_c),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata ({s_last, keep_c, word_c}),
    .re    (issue_c),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (rdata)
  );

  // Output register refills from skid first, then from the returning read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_keep     <= '0;
      m_last     <= 1'b0;
      skid_valid <= 1'b0;
      skid_q     <= '0;
    end else if (pop_c) begin
      if (skid_valid) begin
        {m_last, m_keep, m_data} <= skid_q;
        skid_valid               <= rd_inflight;
        if (rd_inflight) skid_q <= rdata;
      end else begin
        m_valid <= rd_inflight;
        if (rd_inflight) {m_last, m_keep, m_data} <= rdata;
      end
    end else if (!m_valid) begin
      m_valid <= rd_inflight;
      if (rd_inflight) {m_last, m_keep, m_data} <= rdata;
    end else if (rd_inflight) begin
      skid_q     <= rdata;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_widen_fifo.sv
// Directed bench for widen_fifo: vector table of frames plus hand-written flow-control sequences.
module tb_widen_fifo;

  localparam int unsigned NW = 16;
  localparam int unsigned R  = 4;
  localparam int unsigned D  = 8;
  localparam int unsigned AW = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] s_data;
  logic        s_valid, s_last, s_ready;
  logic [63:0] m_data;
  logic [7:0]  m_keep;
  logic        m_last, m_valid, m_ready;
  logic [3:0]  count;

  widen_fifo #(.NARROW_W(NW), .RATIO(R), .DEPTH(D), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .m_data(m_data), .m_keep(m_keep), .m_last(m_last),
    .m_valid(m_valid), .m_ready(m_ready), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } word_t;

  typedef struct packed {
    logic [2:0]       nb;
    logic [3:0][15:0] beats;
    logic [63:0]      exp_data;
    logic [7:0]       exp_keep;
  } vec_t;

  word_t rxq[$];
  int    total = 0;
  int    bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_beat(input logic [15:0] d, input logic l);
    int n = 0;
    s_data  = d;
    s_last  = l;
    s_valid = 1'b1;
    while (!s_ready && n < 200) begin
      step(1);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL send_timeout: s_ready stayed low for %0d cycles, required high", n);
    end
    step(1);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_rx(input int n);
    int c = 0;
    while (rxq.size() < n && c < 100) begin
      step(1);
      c++;
    end
    check("rx_words", 128'(rxq.size()), 128'(n));
  endtask

  // Output monitor: logs popped words and checks hold stability under backpressure.
  logic        held = 1'b0;
  logic [72:0] held_w;
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held && m_valid) check("stall_stable", 128'({m_last, m_keep, m_data}), 128'(held_w));
      if (m_valid && m_ready) rxq.push_back('{m_data, m_keep, m_last});
      held   = m_valid && !m_ready;
      held_w = {m_last, m_keep, m_data};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t        vec [5];
  word_t       w;
  int          acc;
  logic [11:0] pat;

  initial begin
    vec[0] = '{3'd4, {16'h4444, 16'h3333, 16'h2222, 16'h1111}, 64'h4444_3333_2222_1111, 8'hFF};
    vec[1] = '{3'd2, {16'h0000, 16'h0000, 16'hBBBB, 16'hAAAA}, 64'h0000_0000_BBBB_AAAA, 8'h0F};
    vec[2] = '{3'd1, {16'h0000, 16'h0000, 16'h0000, 16'hCCCC}, 64'h0000_0000_0000_CCCC, 8'h03};
    vec[3] = '{3'd3, {16'h0000, 16'h0506, 16'h0304, 16'h0102}, 64'h0000_0506_0304_0102, 8'h3F};
    vec[4] = '{3'd4, {16'hF00D, 16'hCAFE, 16'hBEEF, 16'hDEAD}, 64'hF00D_CAFE_BEEF_DEAD, 8'hFF};

    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    #2;
    check("rst_m_valid", 128'(m_valid), 128'(0));
    check("rst_count",   128'(count), 128'(0));
    check("rst_s_ready", 128'(s_ready), 128'(0));
    check("rst_outputs", 128'({m_last, m_keep, m_data}), 128'(0));
    step(3);
    rst = 1'b0;
    step(1);
    check("ready_after_rst", 128'(s_ready), 128'(1));

    // Latency of a full word: valid two edges after the committing beat.
    m_ready = 1'b1;
    send_beat(16'h1111, 1'b0);
    send_beat(16'h2222, 1'b0);
    send_beat(16'h3333, 1'b0);
    send_beat(16'h4444, 1'b1);
    check("lat_e0", 128'(m_valid), 128'(0));
    step(1);
    check("lat_e1", 128'(m_valid), 128'(0));
    step(1);
    check("lat_e2", 128'(m_valid), 128'(1));
    check("lat_word", 128'({m_last, m_keep, m_data}), 128'({1'b1, 8'hFF, 64'h4444_3333_2222_1111}));
    step(2);
    rxq.delete();

    // Table of frames, each ending with s_last on its final beat.
    for (int v = 0; v < 5; v++) begin
      for (int b = 0; b < int'(vec[v].nb); b++)
        send_beat(vec[v].beats[b], b == int'(vec[v].nb) - 1);
      wait_rx(1);
      if (rxq.size() > 0) begin
        w = rxq.pop_front();
        check($sformatf("vec%0d_data", v), 128'(w.data), 128'(vec[v].exp_data));
        check($sformatf("vec%0d_keep", v), 128'(w.keep), 128'(vec[v].exp_keep));
        check($sformatf("vec%0d_last", v), 128'(w.last), 128'(1));
      end
    end
    step(3);
    check("table_count", 128'(count), 128'(0));
    rxq.delete();

    // Fill with the output stalled, then drain.
    m_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      s_valid = 1'b1;
      s_last  = 1'b0;
      s_data  = 16'(acc);
      if (s_ready) acc++;
      step(1);
    end
    s_valid = 1'b0;
    check("fill_accepted", 128'(acc), 128'(32));
    check("fill_count",    128'(count), 128'(8));
    check("fill_s_ready",  128'(s_ready), 128'(0));
    m_ready = 1'b1;
    step(1);
    check("ready_after_pop", 128'(s_ready), 128'(1));
    wait_rx(8);
    for (int j = 0; j < 8 && rxq.size() > 0; j++) begin
      w = rxq.pop_front();
      check($sformatf("drain%0d", j), 128'({w.last, w.keep, w.data}),
            128'({1'b0, 8'hFF, 16'(4*j+3), 16'(4*j+2), 16'(4*j+1), 16'(4*j)}));
    end
    step(2);
    check("drain_count", 128'(count), 128'(0));
    rxq.delete();

    // Prefilled buffer drains at one word per cycle.
    m_ready = 1'b0;
    for (int i = 0; i < 32; i++) send_beat(16'(100 + i), (i % 4) == 3);
    step(3);
    check("prefill_count", 128'(count), 128'(8));
    m_ready = 1'b1;
    pat = '0;
    for (int c = 0; c < 12; c++) begin
      pat[c] = m_valid;
      step(1);
    end
    check("tput_pattern", 128'(pat), 128'(12'h0FF));
    check("tput_count",   128'(count), 128'(0));
    check("tput_words",   128'(rxq.size()), 128'(8));
    if (rxq.size() == 8) begin
      check("tput_first", 128'(rxq[0].data), 128'({16'd103, 16'd102, 16'd101, 16'd100}));
      check("tput_lastw", 128'(rxq[7].data), 128'({16'd131, 16'd130, 16'd129, 16'd128}));
    end
    rxq.delete();

    // Streaming under a 1,0,0,1 ready pattern.
    m_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 64; i++) send_beat(16'(16'h0200 + i), (i % 8) == 7);
      end
      begin
        int c = 0;
        while (rxq.size() < 16 && c < 600) begin
          m_ready = ((c % 4) == 0) || ((c % 4) == 3);
          step(1);
          c++;
        end
      end
    join
    m_ready = 1'b1;
    check("bp_words", 128'(rxq.size()), 128'(16));
    for (int j = 0; j < 16 && rxq.size() > 0; j++) begin
      w = rxq.pop_front();
      check($sformatf("bp%0d", j), 128'({w.last, w.keep, w.data}),
            128'({(j % 2) == 1, 8'hFF, 16'(16'h0200 + 4*j + 3), 16'(16'h0200 + 4*j + 2),
                  16'(16'h0200 + 4*j + 1), 16'(16'h0200 + 4*j)}));
    end
    step(2);
    check("bp_count", 128'(count), 128'(0));

    // Reset in the middle of a word discards the partial data.
    rxq.delete();
    send_beat(16'h0AAA, 1'b0);
    send_beat(16'h0BBB, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_s_ready", 128'(s_ready), 128'(0));
    step(1);
    rst = 1'b0;
    step(5);
    check("midrst_no_out", 128'(rxq.size()), 128'(0));
    check("midrst_count",  128'(count), 128'(0));
    send_beat(16'h0101, 1'b0);
    send_beat(16'h0202, 1'b0);
    send_beat(16'h0303, 1'b0);
    send_beat(16'h0404, 1'b1);
    wait_rx(1);
    if (rxq.size() > 0) begin
      w = rxq.pop_front();
      check("midrst_word", 128'({w.last, w.keep, w.data}),
            128'({1'b1, 8'hFF, 64'h0404_0303_0202_0101}));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
